// File: rtl/axi4_ram_slave_pkg.sv
// Shared encodings for the AXI4 RAM slave: burst types, response codes, FSM states.
package axi4_ram_slave_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WRESP,
        ST_RDATA
    } state_e;

    typedef struct packed {
        logic [7:0] len;
        logic [1:0] burst;
    } burst_ctl_t;

endpackage

// File: rtl/axi4_ram_slave_ram1rw_be.sv
// Single-port RAM with synchronous read and per-byte write enables.
module ram1rw_be #(
    parameter int DW    = 16,
    parameter int DEPTH = 1024
) (
    input  logic                     clk_i,
    input  logic                     en_i,
    input  logic [DW/8-1:0]          we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [DW-1:0]            wdata_i,
    output logic [DW-1:0]            rdata_o
);

    logic [DW-1:0] mem [DEPTH];

    // Read port only updates on a read access, so rdata_o holds otherwise.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (|we_i) begin
                for (int b = 0; b < DW/8; b++) begin
                    if (we_i[b]) mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end else begin
                rdata_o <= mem[addr_i];
            end
        end
    end

endmodule

// File: rtl/axi4_ram_slave.sv
// AXI4 slave serialising bursts onto a single byte-enabled RAM port.
module axi4_ram_slave
    import axi4_ram_slave_pkg::*;
#(
    parameter int ARCHBITSZ     = 16,
    parameter int AXI4_ID_WIDTH = 4,
    parameter int RAMSIZE       = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [AXI4_ID_WIDTH-1:0] axi4_awid_i,
    input  logic [ARCHBITSZ-1:0]     axi4_awaddr_i,
    input  logic [7:0]               axi4_awlen_i,
    input  logic [1:0]               axi4_awburst_i,
    input  logic                     axi4_awvalid_i,
    output logic                     axi4_awready_o,
    input  logic [ARCHBITSZ-1:0]     axi4_wdata_i,
    input  logic [ARCHBITSZ/8-1:0]   axi4_wstrb_i,
    input  logic                     axi4_wlast_i,
    input  logic                     axi4_wvalid_i,
    output logic                     axi4_wready_o,
    output logic [AXI4_ID_WIDTH-1:0] axi4_bid_o,
    output logic [1:0]               axi4_bresp_o,
    output logic                     axi4_bvalid_o,
    input  logic                     axi4_bready_i,
    input  logic [AXI4_ID_WIDTH-1:0] axi4_arid_i,
    input  logic [ARCHBITSZ-1:0]     axi4_araddr_i,
    input  logic [7:0]               axi4_arlen_i,
    input  logic [1:0]               axi4_arburst_i,
    input  logic                     axi4_arvalid_i,
    output logic                     axi4_arready_o,
    output logic [AXI4_ID_WIDTH-1:0] axi4_rid_o,
    output logic [ARCHBITSZ-1:0]     axi4_rdata_o,
    output logic [1:0]               axi4_rresp_o,
    output logic                     axi4_rlast_o,
    output logic                     axi4_rvalid_o,
    input  logic                     axi4_rready_i
);

    localparam int NB   = ARCHBITSZ / 8;
    localparam int OFFB = $clog2(NB);
    localparam int WAW  = ARCHBITSZ - OFFB;
    localparam int IDXW = $clog2(RAMSIZE);

    state_e                   state_q, state_d;
    logic [AXI4_ID_WIDTH-1:0] id_q;
    logic [WAW-1:0]           addr_q, addr_nxt, aw_waddr, ar_waddr;
    burst_ctl_t               ctl_q;
    logic [7:0]               cnt_q;
    logic                     err_q, rvalid_q, rlast_q;
    logic [1:0]               rresp_q;
    logic                     aw_fire, ar_fire, w_fire, r_fire, w_last;
    logic                     ram_en;
    logic [NB-1:0]            ram_we;
    logic [IDXW-1:0]          ram_addr;
    logic [ARCHBITSZ-1:0]     ram_rdata;
    logic                     unused_addr_bits;

    function automatic logic in_range(input logic [WAW-1:0] a);
        return {1'b0, a} < (WAW+1)'(RAMSIZE);
    endfunction

    assign aw_waddr = axi4_awaddr_i[ARCHBITSZ-1:OFFB];
    assign ar_waddr = axi4_araddr_i[ARCHBITSZ-1:OFFB];
    assign unused_addr_bits = ^{axi4_awaddr_i, axi4_araddr_i};

    // Address arithmetic is modulo 2^WAW; WRAP is handled like INCR.
    assign addr_nxt = (ctl_q.burst == BURST_FIXED) ? addr_q : addr_q + WAW'(1);
    assign w_last   = (cnt_q == ctl_q.len);
    assign aw_fire  = (state_q == ST_IDLE) && axi4_awvalid_i;
    assign ar_fire  = (state_q == ST_IDLE) && !axi4_awvalid_i && axi4_arvalid_i;
    assign w_fire   = (state_q == ST_WDATA) && axi4_wvalid_i;
    assign r_fire   = rvalid_q && axi4_rready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        axi4_awready_o = 1'b0;
        axi4_arready_o = 1'b0;
        axi4_wready_o  = 1'b0;
        axi4_bvalid_o  = 1'b0;
        axi4_bresp_o   = RESP_OKAY;
        case (state_q)
            ST_IDLE: begin
                axi4_awready_o = rst_n_i;
                axi4_arready_o = rst_n_i && !axi4_awvalid_i;
                if (axi4_awvalid_i)      state_d = ST_WDATA;
                else if (axi4_arvalid_i) state_d = ST_RDATA;
            end
            ST_WDATA: begin
                axi4_wready_o = rst_n_i;
                if (axi4_wvalid_i && w_last) state_d = ST_WRESP;
            end
            ST_WRESP: begin
                axi4_bvalid_o = rst_n_i;
                axi4_bresp_o  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (axi4_bready_i) state_d = ST_IDLE;
            end
            ST_RDATA: begin
                if (r_fire && rlast_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Single RAM port: AR first read, next read on each non-final R handshake, or a write beat.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = '0;
        ram_addr = addr_q[IDXW-1:0];
        if (ar_fire) begin
            ram_en   = 1'b1;
            ram_addr = ar_waddr[IDXW-1:0];
        end else if (r_fire && !rlast_q) begin
            ram_en   = 1'b1;
            ram_addr = addr_nxt[IDXW-1:0];
        end else if (w_fire && in_range(addr_q)) begin
            ram_en   = 1'b1;
            ram_we   = axi4_wstrb_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            id_q     <= '0;
            addr_q   <= '0;
            ctl_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rresp_q  <= RESP_OKAY;
        end else begin
            if (aw_fire) begin
                id_q   <= axi4_awid_i;
                addr_q <= aw_waddr;
                ctl_q  <= '{len: axi4_awlen_i, burst: axi4_awburst_i};
                cnt_q  <= '0;
                err_q  <= 1'b0;
            end else if (ar_fire) begin
                id_q     <= axi4_arid_i;
                addr_q   <= ar_waddr;
                ctl_q    <= '{len: axi4_arlen_i, burst: axi4_arburst_i};
                cnt_q    <= '0;
                rvalid_q <= 1'b1;
                rlast_q  <= (axi4_arlen_i == 8'd0);
                rresp_q  <= in_range(ar_waddr) ? RESP_OKAY : RESP_SLVERR;
            end
            if (w_fire) begin
                if (!in_range(addr_q) || (axi4_wlast_i != w_last)) err_q <= 1'b1;
                if (!w_last) begin
                    addr_q <= addr_nxt;
                    cnt_q  <= cnt_q + 8'd1;
                end
            end
            if (r_fire) begin
                if (rlast_q) begin
                    rvalid_q <= 1'b0;
                    rlast_q  <= 1'b0;
                    rresp_q  <= RESP_OKAY;
                end else begin
                    addr_q  <= addr_nxt;
                    cnt_q   <= cnt_q + 8'd1;
                    rlast_q <= (cnt_q + 8'd1 == ctl_q.len);
                    rresp_q <= in_range(addr_nxt) ? RESP_OKAY : RESP_SLVERR;
                end
            end
        end
    end

    assign axi4_bid_o    = id_q;
    assign axi4_rid_o    = id_q;
    assign axi4_rvalid_o = rvalid_q;
    assign axi4_rlast_o  = rlast_q;
    assign axi4_rresp_o  = rresp_q;
    assign axi4_rdata_o  = (rvalid_q && rresp_q == RESP_OKAY) ? ram_rdata : '0;

    ram1rw_be #(.DW(ARCHBITSZ), .DEPTH(RAMSIZE)) u_ram (
        .clk_i   (clk_i),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (axi4_wdata_i),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_axi4_ram_slave.sv
// Directed bench for axi4_ram_slave: writes, reads, bursts, arbitration, range errors, reset.
module tb_axi4_ram_slave;
    import axi4_ram_slave_pkg::*;

    typedef logic [15:0] beat_t [4];

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [3:0]  awid, bid, arid, rid;
    logic [15:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [1:0]  awburst, arburst, wstrb, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    int checks = 0;
    int passed = 0;

    always #5 clk_i = ~clk_i;

    axi4_ram_slave #(.ARCHBITSZ(16), .AXI4_ID_WIDTH(4), .RAMSIZE(1024)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .axi4_awid_i(awid), .axi4_awaddr_i(awaddr), .axi4_awlen_i(awlen),
        .axi4_awburst_i(awburst), .axi4_awvalid_i(awvalid), .axi4_awready_o(awready),
        .axi4_wdata_i(wdata), .axi4_wstrb_i(wstrb), .axi4_wlast_i(wlast),
        .axi4_wvalid_i(wvalid), .axi4_wready_o(wready),
        .axi4_bid_o(bid), .axi4_bresp_o(bresp), .axi4_bvalid_o(bvalid), .axi4_bready_i(bready),
        .axi4_arid_i(arid), .axi4_araddr_i(araddr), .axi4_arlen_i(arlen),
        .axi4_arburst_i(arburst), .axi4_arvalid_i(arvalid), .axi4_arready_o(arready),
        .axi4_rid_o(rid), .axi4_rdata_o(rdata), .axi4_rresp_o(rresp),
        .axi4_rlast_o(rlast), .axi4_rvalid_o(rvalid), .axi4_rready_i(rready)
    );

    task automatic do_write(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input beat_t d, input logic [1:0] strb, input bit bad_last,
                            output logic [1:0] resp, output logic [3:0] id);
        int n;
        @(negedge clk_i);
        awvalid = 1'b1; awaddr = addr; awlen = len; awburst = burst; awid = 4'h3;
        #1 n = 0;
        while (!awready && n < 20) begin @(negedge clk_i); #1 n++; end
        if (n == 20) begin checks++; $display("FAIL wr_aw_timeout: awready=%b want 1", awready); end
        @(posedge clk_i);
        @(negedge clk_i);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (i > 0) @(negedge clk_i);
            wvalid = 1'b1; wdata = d[i]; wstrb = strb; wlast = (i == int'(len)) ^ bad_last;
            #1 n = 0;
            while (!wready && n < 20) begin @(negedge clk_i); #1 n++; end
            if (n == 20) begin checks++; $display("FAIL wr_w_timeout: wready=%b want 1", wready); end
            @(posedge clk_i);
        end
        @(negedge clk_i);
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        #1 n = 0;
        while (!bvalid && n < 20) begin @(negedge clk_i); #1 n++; end
        if (n == 20) begin checks++; $display("FAIL wr_b_timeout: bvalid=%b want 1", bvalid); end
        resp = bresp; id = bid;
        @(posedge clk_i);
        @(negedge clk_i);
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] addr, output logic [15:0] data, output logic [1:0] resp,
                           output logic last, output logic [3:0] id, output int lat);
        int n;
        @(negedge clk_i);
        arvalid = 1'b1; araddr = addr; arlen = 8'd0; arburst = BURST_INCR; arid = 4'h5;
        #1 n = 0;
        while (!arready && n < 20) begin @(negedge clk_i); #1 n++; end
        if (n == 20) begin checks++; $display("FAIL rd_ar_timeout: arready=%b want 1", arready); end
        @(posedge clk_i);
        @(negedge clk_i);
        arvalid = 1'b0;
        #1 lat = 1;
        while (!rvalid && lat < 20) begin @(negedge clk_i); #1 lat++; end
        data = rdata; resp = rresp; last = rlast; id = rid;
        rready = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        #2;
        checks++; if (awready !== 1'b0) $display("FAIL rst_awready: got %b want 0", awready); else passed++;
        checks++; if (arready !== 1'b0) $display("FAIL rst_arready: got %b want 0", arready); else passed++;
        checks++; if ({wready, bvalid, rvalid} !== 3'b000) $display("FAIL rst_valids: got %b want 000", {wready, bvalid, rvalid}); else passed++;
        checks++; if ({bresp, rresp, rlast, rdata} !== 21'd0) $display("FAIL rst_regs: got %h want 0", {bresp, rresp, rlast, rdata}); else passed++;
        @(negedge clk_i); @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i); #1;
        checks++; if ({awready, arready} !== 2'b11) $display("FAIL idle_ready: got %b want 11", {awready, arready}); else passed++;
    endtask

    task automatic test_single();
        logic [15:0] d; logic [1:0] r; logic l; logic [3:0] id; int lat;
        do_write(16'h0010, 8'd0, BURST_INCR, '{16'hA5A5, 16'h0, 16'h0, 16'h0}, 2'b11, 1'b0, r, id);
        checks++; if (r !== RESP_OKAY) $display("FAIL single_bresp: got %b want 00", r); else passed++;
        checks++; if (id !== 4'h3) $display("FAIL single_bid: got %h want 3", id); else passed++;
        do_read(16'h0010, d, r, l, id, lat);
        checks++; if (d !== 16'hA5A5) $display("FAIL single_rdata: got %h want a5a5", d); else passed++;
        checks++; if ({r, l} !== 3'b001) $display("FAIL single_rresp_rlast: got %b want 001", {r, l}); else passed++;
        checks++; if (lat !== 1) $display("FAIL single_latency: got %0d want 1", lat); else passed++;
        checks++; if (id !== 4'h5) $display("FAIL single_rid: got %h want 5", id); else passed++;
    endtask

    task automatic test_strobe();
        logic [15:0] d; logic [1:0] r; logic l; logic [3:0] id; int lat;
        do_write(16'h0030, 8'd0, BURST_INCR, '{16'h1234, 16'h0, 16'h0, 16'h0}, 2'b11, 1'b0, r, id);
        do_write(16'h0030, 8'd0, BURST_INCR, '{16'hFF00, 16'h0, 16'h0, 16'h0}, 2'b10, 1'b0, r, id);
        do_read(16'h0030, d, r, l, id, lat);
        checks++; if (d !== 16'hFF34) $display("FAIL strobe_rdata: got %h want ff34", d); else passed++;
    endtask

    task automatic test_incr_burst();
        logic [1:0] r; logic [3:0] id; int k;
        do_write(16'h0020, 8'd3, BURST_INCR, '{16'h1, 16'h2, 16'h3, 16'h4}, 2'b11, 1'b0, r, id);
        checks++; if (r !== RESP_OKAY) $display("FAIL incr_bresp: got %b want 00", r); else passed++;
        @(negedge clk_i);
        arvalid = 1'b1; araddr = 16'h0020; arlen = 8'd3; arburst = BURST_INCR; arid = 4'h9;
        #1;
        checks++; if (arready !== 1'b1) $display("FAIL incr_arready: got %b want 1", arready); else passed++;
        @(posedge clk_i);
        @(negedge clk_i);
        arvalid = 1'b0;
        k = 0;
        for (int c = 0; c < 12 && k < 4; c++) begin
            rready = (c % 2 == 0);
            #1;
            checks++; if (rvalid !== 1'b1) $display("FAIL incr_rvalid c=%0d: got %b want 1", c, rvalid); else passed++;
            checks++; if (rdata !== 16'(k + 1)) $display("FAIL incr_rdata c=%0d: got %h want %h", c, rdata, 16'(k + 1)); else passed++;
            checks++; if (rlast !== (k == 3)) $display("FAIL incr_rlast c=%0d: got %b want %b", c, rlast, (k == 3)); else passed++;
            @(posedge clk_i);
            if (rready) k++;
            @(negedge clk_i);
        end
        rready = 1'b0;
        #1;
        checks++; if ({rvalid, 3'(k)} !== 4'b0100) $display("FAIL incr_end: rvalid,beats got %b,%0d want 0,4", rvalid, k); else passed++;
    endtask

    task automatic test_collision();
        @(negedge clk_i);
        awvalid = 1'b1; awaddr = 16'h0040; awlen = 8'd0; awburst = BURST_INCR; awid = 4'h1;
        arvalid = 1'b1; araddr = 16'h0040; arlen = 8'd0; arburst = BURST_INCR; arid = 4'h2;
        #1;
        checks++; if ({awready, arready} !== 2'b10) $display("FAIL coll_ready: got %b want 10", {awready, arready}); else passed++;
        @(posedge clk_i);
        @(negedge clk_i);
        awvalid = 1'b0; wvalid = 1'b1; wdata = 16'hBEEF; wstrb = 2'b11; wlast = 1'b1;
        #1;
        checks++; if ({wready, arready} !== 2'b10) $display("FAIL coll_wdata: wready,arready got %b want 10", {wready, arready}); else passed++;
        @(posedge clk_i);
        @(negedge clk_i);
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        #1;
        checks++; if ({bvalid, arready, bresp} !== 4'b1000) $display("FAIL coll_wresp: bvalid,arready,bresp got %b want 1000", {bvalid, arready, bresp}); else passed++;
        @(posedge clk_i);
        @(negedge clk_i);
        bready = 1'b0;
        #1;
        checks++; if (arready !== 1'b1) $display("FAIL coll_ar_after_b: got %b want 1", arready); else passed++;
        @(posedge clk_i);
        @(negedge clk_i);
        arvalid = 1'b0; rready = 1'b1;
        #1;
        checks++; if ({rvalid, rdata} !== {1'b1, 16'hBEEF}) $display("FAIL coll_rdata: got %b/%h want 1/beef", rvalid, rdata); else passed++;
        @(posedge clk_i);
        @(negedge clk_i);
        rready = 1'b0;
    endtask

    task automatic test_range();
        logic [15:0] d; logic [1:0] r; logic l; logic [3:0] id; int lat;
        do_write(16'h0000, 8'd0, BURST_INCR, '{16'h1111, 16'h0, 16'h0, 16'h0}, 2'b11, 1'b0, r, id);
        do_write(16'd2048, 8'd0, BURST_INCR, '{16'h5555, 16'h0, 16'h0, 16'h0}, 2'b11, 1'b0, r, id);
        checks++; if (r !== RESP_SLVERR) $display("FAIL oor_bresp: got %b want 10", r); else passed++;
        do_read(16'h0000, d, r, l, id, lat);
        checks++; if (d !== 16'h1111) $display("FAIL oor_ram_unchanged: got %h want 1111", d); else passed++;
        do_read(16'd2048, d, r, l, id, lat);
        checks++; if ({d, r, l} !== {16'h0, RESP_SLVERR, 1'b1}) $display("FAIL oor_read: got %h/%b/%b want 0000/10/1", d, r, l); else passed++;
        do_write(16'h0052, 8'd0, BURST_INCR, '{16'h7777, 16'h0, 16'h0, 16'h0}, 2'b11, 1'b0, r, id);
        do_write(16'h0050, 8'd2, BURST_FIXED, '{16'h000A, 16'h000B, 16'h000C, 16'h0}, 2'b11, 1'b0, r, id);
        checks++; if (r !== RESP_OKAY) $display("FAIL fixed_bresp: got %b want 00", r); else passed++;
        do_read(16'h0050, d, r, l, id, lat);
        checks++; if (d !== 16'h000C) $display("FAIL fixed_word: got %h want 000c", d); else passed++;
        do_read(16'h0052, d, r, l, id, lat);
        checks++; if (d !== 16'h7777) $display("FAIL fixed_neighbour: got %h want 7777", d); else passed++;
        do_write(16'h0070, 8'd1, BURST_INCR, '{16'h0101, 16'h0202, 16'h0, 16'h0}, 2'b11, 1'b1, r, id);
        checks++; if (r !== RESP_SLVERR) $display("FAIL wlast_err_bresp: got %b want 10", r); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] d; logic [1:0] r; logic l; logic [3:0] id; int lat;
        @(negedge clk_i);
        arvalid = 1'b1; araddr = 16'h0020; arlen = 8'd3; arburst = BURST_INCR; rready = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        arvalid = 1'b0;
        #1;
        checks++; if (rvalid !== 1'b1) $display("FAIL mid_rvalid_before: got %b want 1", rvalid); else passed++;
        #1 rst_n_i = 1'b0;
        #1;
        checks++; if ({rvalid, awready, arready} !== 3'b000) $display("FAIL mid_async_drop: got %b want 000", {rvalid, awready, arready}); else passed++;
        #1 rst_n_i = 1'b1;
        @(negedge clk_i); #1;
        checks++; if ({awready, rvalid} !== 2'b10) $display("FAIL mid_after_release: got %b want 10", {awready, rvalid}); else passed++;
        do_write(16'h0060, 8'd0, BURST_INCR, '{16'hCAFE, 16'h0, 16'h0, 16'h0}, 2'b11, 1'b0, r, id);
        checks++; if (r !== RESP_OKAY) $display("FAIL mid_new_bresp: got %b want 00", r); else passed++;
        do_read(16'h0060, d, r, l, id, lat);
        checks++; if ({d, r, l} !== {16'hCAFE, RESP_OKAY, 1'b1}) $display("FAIL mid_new_read: got %h/%b/%b want cafe/00/1", d, r, l); else passed++;
    endtask

    initial begin
        awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        test_reset();
        test_single();
        test_strobe();
        test_incr_burst();
        test_collision();
        test_range();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d so far", passed, checks);
        $fatal(1);
    end

endmodule
